// File: rtl/booth_multiplier_fsm.sv
// Sequential radix-2 Booth multiplier with a start/ready handshake.
// Handles signed or unsigned operands and produces a registered 2N-bit product.
module booth_multiplier_fsm #(
    parameter int unsigned WORD_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [2*WORD_LENGTH-1:0]   product,
    output logic                       sign,
    output logic                       zero
);

    localparam int unsigned N  = WORD_LENGTH;
    localparam int unsigned CW = $clog2(N + 2);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [N:0]        a_q, a_d;
    logic [N:0]        q_q, q_d;
    logic              qm1_q, qm1_d;
    logic [N:0]        m_q, m_d;
    logic [CW-1:0]     count_q, count_d;
    logic              mode_q, mode_d;
    logic [2*N-1:0]    product_q, product_d;
    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;

    logic [N:0]        a_step;
    logic [N:0]        a_sh;
    logic [N:0]        q_sh;
    logic [2*N-1:0]    product_next;

    // One Booth step: add/sub modulo 2^(N+1), then arithmetic shift of {A,Q,Q-1}.
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b10:   a_step = a_q - m_q;
            2'b01:   a_step = a_q + m_q;
            default: a_step = a_q;
        endcase
        a_sh         = {a_step[N], a_step[N:1]};
        q_sh         = {a_step[0], q_q[N:1]};
        product_next = {a_sh[N-2:0], q_sh};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        count_d   = count_q;
        mode_d    = mode_q;
        product_d = product_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = '0;
                    q_d     = {signed_mode & multiplier[N-1], multiplier};
                    qm1_d   = 1'b0;
                    m_d     = {signed_mode & multiplicand[N-1], multiplicand};
                    count_d = CW'(N + 1);
                    mode_d  = signed_mode;
                end
            end
            StRun: begin
                a_d     = a_sh;
                q_d     = q_sh;
                qm1_d   = q_q[0];
                count_d = count_q - CW'(1);
                // Final step writes the result directly so it is visible in the DONE cycle.
                if (count_q == CW'(1)) begin
                    state_d   = StDone;
                    product_d = product_next;
                    sign_d    = mode_q & product_next[2*N-1];
                    zero_d    = (product_next == '0);
                    done_d    = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            mode_q    <= 1'b0;
            product_q <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            product_q <= product_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == StIdle);
    assign busy    = (state_q == StRun) || (state_q == StDone);
    assign done    = done_q;
    assign product = product_q;
    assign sign    = sign_q;
    assign zero    = zero_q;

endmodule
